// File: rtl/pong_text_render.sv
// Serialises a snapshot of the pong game state as an ASCII frame (cursor-home escape,
// HEIGHT rows of WIDTH pixels each ending CR LF) over a valid/ready byte stream.
module pong_text_render #(
  parameter int WIDTH       = 80,
  parameter int HEIGHT      = 40,
  parameter int PADDLE_SIZE = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [6:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic [6:0] paddle1_y,
  input  logic [6:0] paddle2_y,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, HOME, PIXEL, CR, LF} state_t;

  localparam logic [6:0] COL_LAST   = 7'(WIDTH - 1);
  localparam logic [6:0] ROW_LAST   = 7'(HEIGHT - 1);
  localparam logic [7:0] PADDLE_EXT = 8'(PADDLE_SIZE - 1);

  state_t     state, state_next;
  logic [1:0] hcnt;
  logic [6:0] col, row;
  logic [6:0] snap_ball_x, snap_ball_y, snap_paddle1_y, snap_paddle2_y;
  logic       xfer;
  logic       ball_hit, left_hit, right_hit;
  logic [7:0] row_ext, paddle1_end, paddle2_end;
  logic [7:0] pixel_byte;

  // Every non-idle state presents a byte, so valid never looks at ready.
  assign tx_valid = (state != IDLE);
  assign busy     = (state != IDLE);
  assign xfer     = tx_valid & tx_ready;

  // Paddle bounds are widened to 8 bits so a paddle near row 127 cannot wrap.
  assign row_ext     = {1'b0, row};
  assign paddle1_end = {1'b0, snap_paddle1_y} + PADDLE_EXT;
  assign paddle2_end = {1'b0, snap_paddle2_y} + PADDLE_EXT;
  assign ball_hit    = (col == snap_ball_x) && (row == snap_ball_y);
  assign left_hit    = (col == 7'd0) && (row_ext >= {1'b0, snap_paddle1_y}) &&
                       (row_ext <= paddle1_end);
  assign right_hit   = (col == COL_LAST) && (row_ext >= {1'b0, snap_paddle2_y}) &&
                       (row_ext <= paddle2_end);

  always_comb begin
    pixel_byte = 8'h20;
    if (ball_hit)
      pixel_byte = 8'h4F;
    else if (left_hit || right_hit)
      pixel_byte = 8'h7C;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      hcnt           <= '0;
      col            <= '0;
      row            <= '0;
      snap_ball_x    <= '0;
      snap_ball_y    <= '0;
      snap_paddle1_y <= '0;
      snap_paddle2_y <= '0;
      frame_done     <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            snap_ball_x    <= ball_x;
            snap_ball_y    <= ball_y;
            snap_paddle1_y <= paddle1_y;
            snap_paddle2_y <= paddle2_y;
            hcnt           <= '0;
            col            <= '0;
            row            <= '0;
          end
        end
        HOME: begin
          if (xfer) hcnt <= hcnt + 2'd1;
        end
        PIXEL: begin
          if (xfer) col <= (col == COL_LAST) ? 7'd0 : col + 7'd1;
        end
        LF: begin
          if (xfer) begin
            if (row == ROW_LAST) frame_done <= 1'b1;
            else                 row        <= row + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    tx_data    = 8'h00;
    case (state)
      IDLE: begin
        if (frame_start) state_next = HOME;
      end
      HOME: begin
        case (hcnt)
          2'd0:    tx_data = 8'h1B;
          2'd1:    tx_data = 8'h5B;
          2'd2:    tx_data = 8'h48;
          default: tx_data = 8'h00;
        endcase
        if (xfer && hcnt == 2'd2) state_next = PIXEL;
      end
      PIXEL: begin
        tx_data = pixel_byte;
        if (xfer && col == COL_LAST) state_next = CR;
      end
      CR: begin
        tx_data = 8'h0D;
        if (xfer) state_next = LF;
      end
      LF: begin
        tx_data = 8'h0A;
        if (xfer) state_next = (row == ROW_LAST) ? IDLE : PIXEL;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pong_text_render.sv
// Directed bench for pong_text_render: whole frames are captured from the byte stream
// and compared against an independent frame model plus a table of hand-computed probes.
module tb_pong_text_render;

  localparam int W           = 80;
  localparam int H           = 40;
  localparam int PS          = 6;
  localparam int FRAME_BYTES = 3 + H * (W + 2);

  logic       clk = 1'b0;
  logic       reset, frame_start, tx_ready;
  logic [6:0] ball_x, ball_y, paddle1_y, paddle2_y;
  logic [7:0] tx_data;
  logic       tx_valid, busy, frame_done;

  always #5 clk = ~clk;

  pong_text_render #(.WIDTH(W), .HEIGHT(H), .PADDLE_SIZE(PS)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .ball_x(ball_x), .ball_y(ball_y), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    int         cfg;
    int         row;
    int         col;
    logic [7:0] exp;
  } probe_t;

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] cap_q[$];
  logic [7:0] store [3][FRAME_BYTES];
  int         cyc = 0;
  int         last_xfer_cyc, done_cyc, done_cnt, valid_cyc, stall_errs, done_busy;
  logic       prev_stall;
  logic [7:0] prev_data;

  task automatic check_output(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic clear_capture();
    cap_q.delete();
    done_cnt = 0; done_cyc = -1; last_xfer_cyc = -1;
    valid_cyc = 0; stall_errs = 0; done_busy = 0; prev_stall = 1'b0;
  endtask

  // One clock: drive at the falling edge, observe 1ns later (outputs settle after the rising edge).
  task automatic apply_stimulus(input logic fs, input logic rdy);
    @(negedge clk);
    frame_start = fs;
    tx_ready    = rdy;
    #1;
    cyc++;
    if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_errs++;
    if (tx_valid) valid_cyc++;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) done_busy++;
    end
    if (tx_valid && tx_ready) begin
      cap_q.push_back(tx_data);
      last_xfer_cyc = cyc;
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  endtask

  function automatic logic pick_ready(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  function automatic logic [7:0] model_byte(input int bx, input int by, input int p1,
                                            input int p2, input int idx);
    int k, r, c;
    if (idx == 0) return 8'h1B;
    if (idx == 1) return 8'h5B;
    if (idx == 2) return 8'h48;
    k = idx - 3;
    r = k / (W + 2);
    c = k % (W + 2);
    if (c == W)     return 8'h0D;
    if (c == W + 1) return 8'h0A;
    if (c == bx && r == by) return 8'h4F;
    if (c == 0 && r >= p1 && r <= p1 + PS - 1) return 8'h7C;
    if (c == W - 1 && r >= p2 && r <= p2 + PS - 1) return 8'h7C;
    return 8'h20;
  endfunction

  task automatic drain_frame(input int pct);
    for (int i = 0; i < 20000 && done_cnt == 0; i++) apply_stimulus(1'b0, pick_ready(pct));
    check_output("frame_done_seen", done_cnt, 1);
  endtask

  task automatic run_frame(input int pct);
    clear_capture();
    apply_stimulus(1'b1, pick_ready(pct));
    check_output("idle_before_start", busy, 0);
    apply_stimulus(1'b0, pick_ready(pct));
    check_output("latency_valid", tx_valid, 1);
    check_output("latency_data", tx_data, 8'h1B);
    check_output("latency_busy", busy, 1);
    drain_frame(pct);
  endtask

  task automatic check_frame(input string name, input int bx, input int by,
                             input int p1, input int p2);
    int bad = 0;
    check_output({name, "_len"}, cap_q.size(), FRAME_BYTES);
    for (int i = 0; i < cap_q.size() && i < FRAME_BYTES; i++)
      if (cap_q[i] !== model_byte(bx, by, p1, p2, i)) bad++;
    check_output({name, "_bytes_wrong"}, bad, 0);
    check_output({name, "_done_timing"}, done_cyc, last_xfer_cyc + 1);
    check_output({name, "_done_busy"}, done_busy, 0);
    check_output({name, "_stall_hold"}, stall_errs, 0);
  endtask

  task automatic save_frame(input int slot);
    for (int i = 0; i < FRAME_BYTES; i++)
      store[slot][i] = (i < cap_q.size()) ? cap_q[i] : 8'hXX;
  endtask

  initial begin
    probe_t probes[$];
    int     bad, cnt, idx;
    logic   did;

    // cfg 0: ball (40,20), paddles 17; cfg 1: ball (0,5), p1 3, p2 34; cfg 2: ball_x out of range
    probes.push_back('{0,  0,  0, 8'h20});
    probes.push_back('{0, 16,  0, 8'h20});
    probes.push_back('{0, 17,  0, 8'h7C});
    probes.push_back('{0, 22,  0, 8'h7C});
    probes.push_back('{0, 23,  0, 8'h20});
    probes.push_back('{0, 20, 40, 8'h4F});
    probes.push_back('{0, 20, 41, 8'h20});
    probes.push_back('{0, 17, 79, 8'h7C});
    probes.push_back('{0, 16, 79, 8'h20});
    probes.push_back('{0, 20, 80, 8'h0D});
    probes.push_back('{0, 20, 81, 8'h0A});
    probes.push_back('{1,  5,  0, 8'h4F});
    probes.push_back('{1,  3,  0, 8'h7C});
    probes.push_back('{1,  4,  0, 8'h7C});
    probes.push_back('{1,  6,  0, 8'h7C});
    probes.push_back('{1,  8,  0, 8'h7C});
    probes.push_back('{1,  2,  0, 8'h20});
    probes.push_back('{1,  9,  0, 8'h20});
    probes.push_back('{1, 34, 79, 8'h7C});
    probes.push_back('{1, 39, 79, 8'h7C});
    probes.push_back('{1, 33, 79, 8'h20});
    probes.push_back('{2,  5,  0, 8'h7C});
    probes.push_back('{2,  0,  0, 8'h20});

    reset = 1'b1; frame_start = 1'b0; tx_ready = 1'b0;
    ball_x = 7'd0; ball_y = 7'd0; paddle1_y = 7'd0; paddle2_y = 7'd0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_tx_data", tx_data, 8'h00);
    check_output("reset_tx_valid", tx_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_frame_done", frame_done, 0);
    reset = 1'b0;

    $display("[TB] idle after reset");
    clear_capture();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, 1'b1);
      if (tx_valid || busy || frame_done) bad++;
    end
    check_output("idle_quiet", bad, 0);

    $display("[TB] default frame");
    ball_x = 7'd40; ball_y = 7'd20; paddle1_y = 7'd17; paddle2_y = 7'd17;
    run_frame(100);
    check_frame("default", 40, 20, 17, 17);
    check_output("default_valid_cycles", valid_cyc, FRAME_BYTES);
    bad = 0;
    for (int r = 0; r < H; r++) begin
      idx = 3 + r * (W + 2) + W;
      if (idx + 1 >= cap_q.size() || cap_q[idx] !== 8'h0D || cap_q[idx + 1] !== 8'h0A) bad++;
    end
    check_output("default_line_endings", bad, 0);
    save_frame(0);

    $display("[TB] backpressure");
    run_frame(30);
    check_frame("backpressure", 40, 20, 17, 17);
    bad = 0;
    for (int i = 0; i < FRAME_BYTES; i++)
      if (i >= cap_q.size() || cap_q[i] !== store[0][i]) bad++;
    check_output("backpressure_same_as_default", bad, 0);

    $display("[TB] priority and corners");
    ball_x = 7'd0; ball_y = 7'd5; paddle1_y = 7'd3; paddle2_y = 7'd34;
    run_frame(100);
    check_frame("corner", 0, 5, 3, 34);
    save_frame(1);
    ball_x = 7'd100;
    run_frame(100);
    check_frame("offscreen", 100, 5, 3, 34);
    save_frame(2);
    cnt = 0;
    foreach (cap_q[i]) if (cap_q[i] == 8'h4F) cnt++;
    check_output("offscreen_no_ball", cnt, 0);

    foreach (probes[p]) begin
      idx = 3 + probes[p].row * (W + 2) + probes[p].col;
      check_output($sformatf("probe_cfg%0d_r%0d_c%0d", probes[p].cfg, probes[p].row, probes[p].col),
                   store[probes[p].cfg][idx], probes[p].exp);
    end

    $display("[TB] snapshot and ignored start");
    ball_x = 7'd40; ball_y = 7'd20; paddle1_y = 7'd17; paddle2_y = 7'd17;
    clear_capture();
    did = 1'b0;
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
      if (!did && cap_q.size() == 3 + 10 * (W + 2) + 5) begin
        ball_y = 7'd30;
        did    = 1'b1;
        apply_stimulus(1'b1, 1'b1);
      end else begin
        apply_stimulus(1'b0, 1'b1);
      end
    end
    check_output("snapshot_done_seen", done_cnt, 1);
    check_frame("snapshot", 40, 20, 17, 17);
    valid_cyc = 0;
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1);
    check_output("no_queued_frame", valid_cyc, 0);
    ball_y = 7'd20;

    $display("[TB] back-to-back frames");
    run_frame(100);
    check_frame("b2b_first", 40, 20, 17, 17);
    frame_start = 1'b1;
    clear_capture();
    apply_stimulus(1'b0, 1'b1);
    check_output("b2b_valid", tx_valid, 1);
    check_output("b2b_data", tx_data, 8'h1B);
    drain_frame(100);
    check_frame("b2b_second", 40, 20, 17, 17);

    $display("[TB] reset mid-frame");
    clear_capture();
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 2000 && cap_q.size() < 500; i++) apply_stimulus(1'b0, 1'b1);
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b1);
    check_output("midreset_valid", tx_valid, 0);
    check_output("midreset_busy", busy, 0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1);
    check_output("midreset_no_done", done_cnt, 0);
    run_frame(100);
    check_frame("restart", 40, 20, 17, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pong_text_render.md
# pong_text_render

Reader end of the pong game-state interface: consumes `ball_x`, `ball_y`, `paddle1_y` and `paddle2_y` from the game engine and serialises one full playfield frame as an ASCII byte stream. A downstream UART transmitter drains the stream over a valid/ready handshake. The block sits between the engine and the serial TX path. It snapshots the game state at frame start so that every frame it emits is self-consistent.

## Interface
Parameters:
- `WIDTH`, 80: playfield columns.
- `HEIGHT`, 40: playfield rows.
- `PADDLE_SIZE`, 6: paddle height in rows.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `frame_start`  in  1  request one frame; sampled only in IDLE.
- `ball_x`  in  7  ball column.
- `ball_y`  in  7  ball row.
- `paddle1_y`  in  7  left paddle top row.
- `paddle2_y`  in  7  right paddle top row.
- `tx_data`  out  8  current byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse after the last byte is accepted.

## Operation
States: IDLE, HOME, PIXEL, CR, LF.
- **IDLE**
  - `frame_start`=1 latches all four position inputs into snapshot registers.
  - Clears `hcnt`/`col`/`row`, then moves to HOME.
- **HOME**
  - Emits 0x1B, 0x5B, 0x48 in order (cursor-home escape), indexed by a 2-bit `hcnt`.
  - Moves to PIXEL after the third byte is accepted.
- **PIXEL**
  - Emits one byte for (`col`, `row`). Priority order:
    - ball, `col`==ball_x and `row`==ball_y: 'O' (0x4F).
    - left paddle, `col`==0 and paddle1_y ≤ `row` ≤ paddle1_y+PADDLE_SIZE−1: '|' (0x7C).
    - right paddle, `col`==WIDTH−1 and same test with paddle2_y: '|' (0x7C).
    - otherwise: ' ' (0x20).
  - Accepted byte with `col`==WIDTH−1: clear `col`, go to CR. Otherwise increment `col`.
- **CR**: emits 0x0D, then goes to LF.
- **LF**
  - Emits 0x0A.
  - If `row`==HEIGHT−1: go to IDLE and pulse `frame_done`.
  - Otherwise: increment `row` and go to PIXEL.
- Paddle compare uses 8-bit sums; no wrap.
- Positions ≥ WIDTH or ≥ HEIGHT simply never match, so that object is not drawn. No error is flagged.
- Bytes per frame: 3 + HEIGHT·(WIDTH+2), which is 3283 at defaults.
- Inputs that change mid-frame have no effect; only the snapshot is used.
- `frame_start` outside IDLE is ignored and not queued.

## Timing
- Reset values:
  - state IDLE.
  - `tx_valid`=0, `tx_data`=0x00.
  - `busy`=0, `frame_done`=0.
  - counters 0, snapshots 0.
- **Reset mid-frame**
  - Next cycle the block is in IDLE and `tx_valid`=0.
  - The partial frame is abandoned and no `frame_done` is issued.
- **Handshake**
  - A transfer occurs on a cycle where `tx_valid` and `tx_ready` are both 1.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` holds stable and `tx_valid` stays high.
  - `tx_valid` never depends combinationally on `tx_ready`.
- **Latency**
  - `frame_start` sampled high in IDLE at cycle N.
  - Cycle N+1: `busy`=1, `tx_valid`=1, `tx_data`=0x1B.
- **Throughput**
  - One byte per cycle when `tx_ready` is held 1.
  - A full frame then takes exactly 3283 cycles of `tx_valid`, with no bubbles between states or rows.
- `busy`=1 exactly in non-IDLE states.
- `frame_done`
  - Registered; high for the single cycle after the final LF transfer, while the state is already IDLE.
  - A `frame_start` in that same cycle is accepted, giving back-to-back frames with one idle cycle between them.

## Test plan
- **Reset then idle:** `reset` for 2 cycles, no `frame_start` for 20 cycles → `tx_valid`=0, `busy`=0, `frame_done`=0 throughout.
- **Default frame:**
  - Stimulus: ball (40,20), paddles at 17, `tx_ready`=1, one `frame_start`.
  - Byte count: exactly 3283 bytes; first three are 1B 5B 48.
  - Left column: rows 17–22 have 0x7C at col 0; rows 0–16 and 23–39 have 0x20 at col 0.
  - Ball: byte index 3 + 20·82 + 40 = 1683 is 0x4F.
  - Line endings: every row ends 0D 0A.
  - Completion: `frame_done` pulses once, one cycle after the last transfer.
- **Backpressure:**
  - Stimulus: same frame with `tx_ready` pseudo-random at about 30% duty.
  - Response: captured byte sequence is identical to the previous test.
  - Stability: `tx_data` is stable and `tx_valid` stays high on every stalled cycle.
- **Priority and corners:**
  - Stimulus: ball (0,5), paddle1_y=3, paddle2_y=34.
  - Response: (0,5) is 'O'; (0,3), (0,4), (0,6), (0,7), (0,8) are '|'; (79,34)–(79,39) are '|'.
  - Out-of-range: ball_x=100 draws no 'O' anywhere.
- **Snapshot/ignore:**
  - Stimulus: change ball_y and pulse `frame_start` during row 10.
  - Response: the frame uses the original ball row; no second frame starts.
  - Back-to-back: a `frame_start` in the `frame_done` cycle starts the next frame, with 0x1B on the following cycle.
- **Reset mid-frame:**
  - Stimulus: assert `reset` at byte 500.
  - Response: next cycle `tx_valid`=0 and `busy`=0, with no `frame_done`.
  - Restart: a subsequent `frame_start` produces a complete 3283-byte frame starting 1B 5B 48.
